// File: rtl/tff_prog_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tff_prog_timer: programmable down-counting timer, one-shot or periodic,    |
// | with stop and a one-cycle expire pulse. Optional prescaler: TIMER_PRESCALE_EN |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tff_prog_timer #(
  parameter int W       = 8,
  parameter int PRE_DIV = 4
) (
  input  logic         clk,
  input  logic         clr_b,
  input  logic         start,
  input  logic         stop,
  input  logic         periodic,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         expire
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [W-1:0] c_one = W'(1);

  state_t       r_state, w_state_nxt;
  logic [W-1:0] r_count, w_count_nxt;
  logic [W-1:0] r_reload, w_reload_nxt;
  logic         r_mode, w_mode_nxt;
  logic         r_expire, w_expire_nxt;
  logic         w_tick;

  if (W < 2 || PRE_DIV < 2) begin : g_param_check
    $error("tff_prog_timer: W and PRE_DIV must both be >= 2");
  end

`ifdef TIMER_PRESCALE_EN
  localparam int PW = $clog2(PRE_DIV);
  localparam logic [PW-1:0] c_presc_max = PW'(PRE_DIV - 1);

  logic [PW-1:0] r_presc;
  logic          w_clr_presc;

  // Any start or stop realigns the tick phase to the command.
  assign w_clr_presc = start || stop;

  always_ff @(posedge clk or negedge clr_b) begin
    if (!clr_b) begin
      r_presc <= '0;
    end else if (w_clr_presc || r_state != S_RUN || r_presc == c_presc_max) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick = (r_state == S_RUN) && (r_presc == c_presc_max);
`else
  assign w_tick = (r_state == S_RUN);
`endif

  always_ff @(posedge clk or negedge clr_b) begin
    if (!clr_b) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_mode   <= 1'b0;
      r_expire <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_mode   <= w_mode_nxt;
      r_expire <= w_expire_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_mode_nxt   = r_mode;
    w_expire_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && load_val != '0) begin
          w_count_nxt  = load_val;
          w_reload_nxt = load_val;
          w_mode_nxt   = periodic;
          w_state_nxt  = S_RUN;
        end
      end
      S_RUN: begin
        // Priority: stop (or a zero-length restart), then restart, then tick.
        if (stop || (start && load_val == '0)) begin
          w_count_nxt = '0;
          w_state_nxt = S_IDLE;
        end else if (start) begin
          w_count_nxt  = load_val;
          w_reload_nxt = load_val;
          w_mode_nxt   = periodic;
        end else if (w_tick) begin
          if (r_count == c_one) begin
            w_expire_nxt = 1'b1;
            if (r_mode) begin
              w_count_nxt = r_reload;
            end else begin
              w_count_nxt = '0;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_count_nxt = r_count - 1'b1;
          end
        end
      end
    endcase
  end

  assign count  = r_count;
  assign busy   = (r_state == S_RUN);
  assign expire = r_expire;

endmodule
`default_nettype wire

// File: tb/tb_tff_prog_timer.sv
`default_nettype none
// Self-checking bench for tff_prog_timer: constant vector table, directed
// corner sequences and a randomized run against a behavioural model.
module tb_tff_prog_timer;

  localparam int W       = 8;
  localparam int PRE_DIV = 4;

  logic         clk = 1'b0;
  logic         clr_b;
  logic         start, stop, periodic;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         busy, expire;

  int n_chk  = 0;
  int n_pass = 0;

  tff_prog_timer #(.W(W), .PRE_DIV(PRE_DIV)) dut (
    .clk      (clk),
    .clr_b    (clr_b),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .load_val (load_val),
    .count    (count),
    .busy     (busy),
    .expire   (expire)
  );

  always #5 clk = ~clk;

  // Behavioural model: a timer is either idle or running with a remaining
  // count; ticks arrive every cycle, or every PRE_DIV cycles when prescaled.
  bit           m_run;
  int           m_count, m_reload, m_phase;
  bit           m_per, m_expire;

  task automatic model_reset();
    m_run = 0; m_count = 0; m_reload = 0; m_phase = 0; m_per = 0; m_expire = 0;
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit per, input int lv);
    bit tick;
    m_expire = 0;
    if (!m_run) begin
      if (st && lv != 0) begin
        m_run = 1; m_count = lv; m_reload = lv; m_per = per; m_phase = 0;
      end
    end else if (sp || (st && lv == 0)) begin
      m_run = 0; m_count = 0; m_phase = 0;
    end else if (st) begin
      m_count = lv; m_reload = lv; m_per = per; m_phase = 0;
    end else begin
`ifdef TIMER_PRESCALE_EN
      m_phase = m_phase + 1;
      tick = (m_phase == PRE_DIV);
      if (tick) m_phase = 0;
`else
      tick = 1;
`endif
      if (tick) begin
        m_count = m_count - 1;
        if (m_count == 0) begin
          m_expire = 1;
          if (m_per) m_count = m_reload;
          else m_run = 0;
        end
      end
    end
  endtask

  task automatic cyc(input bit st, input bit sp, input bit per, input int lv);
    start = st; stop = sp; periodic = per; load_val = W'(lv);
    @(posedge clk);
    model_edge(st, sp, per, lv);
    #1;
    start = 0; stop = 0;
  endtask

  task automatic check(input string name, input int exp_cnt, input bit exp_busy, input bit exp_exp);
    n_chk++;
    if (count === W'(exp_cnt) && busy === exp_busy && expire === exp_exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got count=%0d busy=%b expire=%b, want count=%0d busy=%b expire=%b",
               name, count, busy, expire, exp_cnt, exp_busy, exp_exp);
    end
  endtask

  typedef struct {
    bit st, sp, per;
    int lv;
    int cnt;
    bit bsy, ex;
  } vec_t;

  function automatic vec_t mk(bit st, bit sp, bit per, int lv, int cnt, bit bsy, bit ex);
    vec_t v;
    v.st = st; v.sp = sp; v.per = per; v.lv = lv; v.cnt = cnt; v.bsy = bsy; v.ex = ex;
    return v;
  endfunction

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   n_exp, lat;
    bit   seen;

    clr_b = 0; start = 0; stop = 0; periodic = 0; load_val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset", 0, 0, 0);
    @(negedge clk) clr_b = 1;

`ifndef TIMER_PRESCALE_EN
    //          st sp per lv   cnt bsy ex
    vecs.push_back(mk(1, 0, 0, 5,   5, 1, 0));  // one-shot 5
    vecs.push_back(mk(0, 0, 0, 0,   4, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 1));  // expire 5 after start
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0));  // zero load in IDLE ignored
    vecs.push_back(mk(0, 1, 0, 0,   0, 0, 0));  // stop in IDLE
    vecs.push_back(mk(1, 0, 1, 3,   3, 1, 0));  // periodic 3
    vecs.push_back(mk(0, 0, 0, 0,   2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   3, 1, 1));  // wrap 1->3
    vecs.push_back(mk(0, 0, 0, 0,   2, 1, 0));
    vecs.push_back(mk(1, 1, 0, 9,   0, 0, 0));  // stop beats start
    vecs.push_back(mk(1, 0, 0, 2,   2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 7,   7, 1, 0));  // restart at count 1: no expire
    vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0));  // restart with 0 acts as stop
    vecs.push_back(mk(1, 0, 1, 1,   1, 1, 0));  // periodic N=1
    vecs.push_back(mk(0, 0, 0, 0,   1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0,   1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0,   0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 255, 255, 1, 0)); // max period
    vecs.push_back(mk(0, 0, 0, 0,   254, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0,   0, 0, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].st, vecs[i].sp, vecs[i].per, vecs[i].lv);
      check($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].bsy, vecs[i].ex);
    end

    // Periodic N=3 over four periods.
    cyc(1, 0, 1, 3);
    n_exp = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 0, 0, 0);
      check($sformatf("per3_c%0d", i), (i % 3 == 0) ? 3 : 3 - (i % 3), 1, (i % 3 == 0));
    end
    cyc(0, 1, 0, 0);

    // Restart from count 1, then expire exactly 7 cycles later.
    cyc(1, 0, 0, 2);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 7);
    check("restart_load", 7, 1, 0);
    seen = 0; lat = 0;
    for (int i = 1; i <= 12 && !seen; i++) begin
      cyc(0, 0, 0, 0);
      if (expire) begin seen = 1; lat = i; end
    end
    n_chk++;
    if (seen && lat == 7) n_pass++;
    else $display("FAIL restart_latency: got %0d cycles (seen=%0d), want 7", lat, seen);
`else
    // Prescaled one-shot N=3: expire N*PRE_DIV cycles after start.
    cyc(1, 0, 0, 3);
    seen = 0; lat = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      cyc(0, 0, 0, 0);
      if (expire) begin seen = 1; lat = i; end
    end
    n_chk++;
    if (seen && lat == 3 * PRE_DIV) n_pass++;
    else $display("FAIL presc_latency: got %0d cycles (seen=%0d), want %0d", lat, seen, 3 * PRE_DIV);
    check("presc_done", 0, 0, 1);
    cyc(0, 0, 0, 0);
`endif

    // Asynchronous reset mid-run takes effect without a clock edge.
    cyc(1, 0, 0, 5);
    check("pre_async", 5, 1, 0);
    #2 clr_b = 0;
    #1 check("async_reset", 0, 0, 0);
    model_reset();
    @(negedge clk) clr_b = 1;

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      bit st, sp, per;
      int lv;
      st  = ($urandom_range(0, 9) == 0);
      sp  = ($urandom_range(0, 19) == 0);
      per = $urandom_range(0, 1);
      lv  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      cyc(st, sp, per, lv);
      check($sformatf("rand%0d", i), m_count, m_run, m_expire);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
